// File: rtl/router_pkt_tx.sv
// router_pkt_tx: packet transmitter that feeds the router input port.
// Buffers a host payload (1..63 bytes), then sends header {len, addr}, the payload and an
// even-XOR parity byte. Each presented byte is consumed on any rising edge with busy_i == 0.
//
// Ports:
//   clock, resetn        clock, synchronous active-low reset
//   cmd_valid_i/ready_o  host command handshake (ready only in idle)
//   cmd_addr_i, cmd_len_i destination port 0..2 and payload length 1..63
//   pl_valid_i/ready_o   payload byte handshake (ready only while loading)
//   pl_data_i            payload byte
//   busy_i               router back-pressure
//   pkt_valid_o          router pkt_valid (registered)
//   data_out_o           router data_in (registered)
//   done_o, abort_o, cmd_err_o  one-cycle status pulses
//   tx_active_o          high while header, payload or parity is presented
module router_pkt_tx #(
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned BUSY_TO    = 255
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       cmd_valid_i,
  input  logic [1:0] cmd_addr_i,
  input  logic [5:0] cmd_len_i,
  output logic       cmd_ready_o,
  input  logic       pl_valid_i,
  input  logic [7:0] pl_data_i,
  output logic       pl_ready_o,
  input  logic       busy_i,
  output logic       pkt_valid_o,
  output logic [7:0] data_out_o,
  output logic       done_o,
  output logic       abort_o,
  output logic       cmd_err_o,
  output logic       tx_active_o
);

  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StHeader,
    StPayload,
    StParity,
    StGap
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      mem_q [64];
  logic [5:0]      wr_ptr_q, wr_ptr_d;
  logic [5:0]      rd_ptr_q, rd_ptr_d;
  logic [5:0]      len_q, len_d;
  logic [1:0]      addr_q, addr_d;
  logic [7:0]      par_q, par_d;
  logic [7:0]      data_q, data_d;
  logic [7:0]      stall_q, stall_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic            pkt_valid_q, pkt_valid_d;
  logic            done_q, done_d;
  logic            abort_q, abort_d;
  logic            cmd_err_q, cmd_err_d;

  logic            mem_we;
  logic [7:0]      header;
  logic            active;
  logic            stalling;
  logic            to_hit;

  assign header   = {len_q, addr_q};
  assign active   = (state_q == StHeader) || (state_q == StPayload) || (state_q == StParity);
  assign stalling = active && busy_i;
  // Timeout fires on the edge that would take the stall count to BUSY_TO.
  assign to_hit   = (BUSY_TO != 0) && stalling && (stall_q == 8'(BUSY_TO - 1));

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    len_d       = len_q;
    addr_d      = addr_q;
    par_d       = par_q;
    data_d      = data_q;
    gap_d       = gap_q;
    pkt_valid_d = pkt_valid_q;
    done_d      = 1'b0;
    abort_d     = 1'b0;
    cmd_err_d   = 1'b0;
    mem_we      = 1'b0;
    // Any consumed byte (or leaving the transmit states) clears the stall count.
    stall_d     = stalling ? stall_q + 8'd1 : 8'd0;

    case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          if ((cmd_addr_i == 2'd3) || (cmd_len_i == 6'd0)) begin
            cmd_err_d = 1'b1;
          end else begin
            addr_d   = cmd_addr_i;
            len_d    = cmd_len_i;
            par_d    = {cmd_len_i, cmd_addr_i};
            wr_ptr_d = 6'd0;
            state_d  = StLoad;
          end
        end
      end
      StLoad: begin
        if (pl_valid_i) begin
          mem_we   = 1'b1;
          par_d    = par_q ^ pl_data_i;
          wr_ptr_d = wr_ptr_q + 6'd1;
          // len <= 63 so wr_ptr + 1 cannot overflow before matching.
          if (wr_ptr_q + 6'd1 == len_q) begin
            state_d     = StHeader;
            pkt_valid_d = 1'b1;
            data_d      = header;
          end
        end
      end
      StHeader: begin
        if (!busy_i) begin
          data_d   = mem_q[0];
          rd_ptr_d = 6'd1;
          state_d  = StPayload;
        end
      end
      StPayload: begin
        if (!busy_i) begin
          if (rd_ptr_q == len_q) begin
            pkt_valid_d = 1'b0;
            data_d      = par_q;
            state_d     = StParity;
          end else begin
            data_d   = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + 6'd1;
          end
        end
      end
      StParity: begin
        if (!busy_i) begin
          data_d  = 8'h00;
          gap_d   = GapW'(GAP_CYCLES - 1);
          state_d = StGap;
        end
      end
      StGap: begin
        if (gap_q == '0) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          gap_d = gap_q - GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (to_hit) begin
      pkt_valid_d = 1'b0;
      data_d      = 8'h00;
      abort_d     = 1'b1;
      stall_d     = 8'd0;
      state_d     = StIdle;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= StIdle;
      wr_ptr_q    <= 6'd0;
      rd_ptr_q    <= 6'd0;
      len_q       <= 6'd0;
      addr_q      <= 2'd0;
      par_q       <= 8'h00;
      data_q      <= 8'h00;
      stall_q     <= 8'd0;
      gap_q       <= '0;
      pkt_valid_q <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
      par_q       <= par_d;
      data_q      <= data_d;
      stall_q     <= stall_d;
      gap_q       <= gap_d;
      pkt_valid_q <= pkt_valid_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  // Buffer contents are not reset; they are always rewritten before being read.
  always_ff @(posedge clock) begin
    if (resetn && mem_we) begin
      mem_q[wr_ptr_q] <= pl_data_i;
    end
  end

  assign cmd_ready_o = (state_q == StIdle);
  assign pl_ready_o  = (state_q == StLoad);
  assign tx_active_o = active;
  assign pkt_valid_o = pkt_valid_q;
  assign data_out_o  = data_q;
  assign done_o      = done_q;
  assign abort_o     = abort_q;
  assign cmd_err_o   = cmd_err_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Scoreboard bench for router_pkt_tx: the stimulus process pushes the expected byte stream
// and status pulses; a negedge monitor compares presented bytes and pulses against the queue.
module tb_router_pkt_tx;

  localparam int unsigned GapCycles = 2;
  localparam int unsigned BusyTo    = 8;

  typedef enum logic [1:0] {KByte, KDone, KAbort, KErr} kind_e;
  typedef struct packed {
    kind_e      kind;
    logic       pv;
    logic [7:0] data;
  } exp_t;

  logic       clock = 1'b0;
  logic       resetn;
  logic       cmd_valid;
  logic [1:0] cmd_addr;
  logic [5:0] cmd_len;
  logic       cmd_ready;
  logic       pl_valid;
  logic [7:0] pl_data;
  logic       pl_ready;
  logic       busy;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       done;
  logic       abort;
  logic       cmd_err;
  logic       tx_active;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  int   cyc       = 0;
  int   par_cyc   = 0;
  int   stall_cnt = 0;
  exp_t mon_e;
  kind_e mon_k;

  router_pkt_tx #(
    .GAP_CYCLES(GapCycles),
    .BUSY_TO   (BusyTo)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .cmd_valid_i(cmd_valid),
    .cmd_addr_i (cmd_addr),
    .cmd_len_i  (cmd_len),
    .cmd_ready_o(cmd_ready),
    .pl_valid_i (pl_valid),
    .pl_data_i  (pl_data),
    .pl_ready_o (pl_ready),
    .busy_i     (busy),
    .pkt_valid_o(pkt_valid),
    .data_out_o (data_out),
    .done_o     (done),
    .abort_o    (abort),
    .cmd_err_o  (cmd_err),
    .tx_active_o(tx_active)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input kind_e k, input logic pv, input logic [7:0] d);
    exp_t e;
    e.kind = k;
    e.pv   = pv;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Queue a full packet: header, payload, parity, done.
  task automatic expect_pkt(input logic [1:0] a, input logic [5:0] n, input logic [7:0] pl[$]);
    logic [7:0] par;
    par = {n, a};
    push(KByte, 1'b1, {n, a});
    foreach (pl[i]) begin
      push(KByte, 1'b1, pl[i]);
      par ^= pl[i];
    end
    push(KByte, 1'b0, par);
    push(KDone, 1'b0, 8'h00);
  endtask

  task automatic send_cmd(input logic [1:0] a, input logic [5:0] n);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = n;
    step();
    cmd_valid = 1'b0;
  endtask

  // Load payload with 'idle' empty cycles before each byte.
  task automatic load(input logic [7:0] pl[$], input int idle);
    foreach (pl[i]) begin
      pl_valid = 1'b0;
      repeat (idle) step();
      pl_valid = 1'b1;
      pl_data  = pl[i];
      step();
    end
    pl_valid = 1'b0;
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound && exp_q.size() != 0; i++) step();
    if (exp_q.size() != 0) begin
      check("drain_timeout", 32'(exp_q.size()), 0);
      exp_q.delete();
    end
  endtask

  // Monitor: compares presented bytes and pulses against the scoreboard.
  always @(negedge clock) begin
    cyc++;
    if (!resetn) begin
      stall_cnt = 0;
    end else begin
      if (tx_active) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", 32'({pkt_valid, data_out}), 32'h1ff);
        end else begin
          mon_e = exp_q[0];
          check("tx_byte", 32'({pkt_valid, data_out}), 32'({mon_e.pv, mon_e.data}));
          if (busy) begin
            stall_cnt++;
          end else begin
            stall_cnt = 0;
            check("consume_kind", 32'(KByte), 32'(mon_e.kind));
            void'(exp_q.pop_front());
            if (!mon_e.pv) par_cyc = cyc;
          end
        end
      end
      if (done || abort || cmd_err) begin
        mon_k = done ? KDone : (abort ? KAbort : KErr);
        check("one_pulse", 32'({1'b0, done} + {1'b0, abort} + {1'b0, cmd_err}), 1);
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 32'(mon_k), 32'hff);
        end else begin
          mon_e = exp_q.pop_front();
          check("pulse_kind", 32'(mon_k), 32'(mon_e.kind));
          if (mon_k == KDone) begin
            check("done_latency", 32'(cyc - par_cyc), GapCycles + 1);
          end else if (mon_k == KAbort) begin
            check("abort_stalls", 32'(stall_cnt), BusyTo);
            check("abort_out", 32'({pkt_valid, data_out, cmd_ready}), 32'({1'b0, 8'h00, 1'b1}));
            stall_cnt = 0;
          end else begin
            check("err_state", 32'({cmd_ready, pl_ready, tx_active, pkt_valid}), 32'b1000);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [7:0] pl[$];
    resetn    = 1'b0;
    cmd_valid = 1'b0;
    cmd_addr  = 2'd0;
    cmd_len   = 6'd0;
    pl_valid  = 1'b0;
    pl_data   = 8'h00;
    busy      = 1'b0;
    step();
    step();
    resetn = 1'b1;
    check("rst_out", 32'({pkt_valid, data_out}), 0);
    check("rst_ready", 32'({cmd_ready, pl_ready, tx_active}), 32'b100);
    check("rst_pulses", 32'({done, abort, cmd_err}), 0);

    // Basic packet, no back-pressure.
    pl = '{8'h11, 8'h22, 8'h33};
    expect_pkt(2'd1, 6'd3, pl);
    send_cmd(2'd1, 6'd3);
    load(pl, 0);
    check("hdr_on_last_load", 32'({tx_active, pkt_valid, data_out}), 32'({2'b11, 8'h0D}));
    drain(30);

    // Same packet, 0x22 held for 3 busy cycles.
    expect_pkt(2'd1, 6'd3, pl);
    send_cmd(2'd1, 6'd3);
    load(pl, 0);
    step();
    step();
    busy = 1'b1;
    step();
    step();
    step();
    busy = 1'b0;
    drain(30);

    // Illegal commands; stray payload strobes must be ignored.
    push(KErr, 1'b0, 8'h00);
    push(KErr, 1'b0, 8'h00);
    pl_valid  = 1'b1;
    pl_data   = 8'hFF;
    cmd_valid = 1'b1;
    cmd_addr  = 2'd3;
    cmd_len   = 6'd5;
    step();
    cmd_addr = 2'd0;
    cmd_len  = 6'd0;
    step();
    cmd_valid = 1'b0;
    step();
    check("err_idle", 32'({cmd_ready, pl_ready, tx_active, pkt_valid}), 32'b1000);
    pl_valid = 1'b0;
    drain(10);

    // Maximum length.
    pl = {};
    for (int i = 0; i < 63; i++) pl.push_back(8'(i));
    expect_pkt(2'd2, 6'd63, pl);
    check("max_parity_model", 32'(exp_q[64].data), 32'hC1);
    send_cmd(2'd2, 6'd63);
    load(pl, 0);
    check("max_hdr", 32'(data_out), 32'hFE);
    drain(200);

    // Timeout while the header is stalled.
    pl = '{8'h11, 8'h22, 8'h33};
    push(KAbort, 1'b1, 8'h0D);
    busy = 1'b1;
    send_cmd(2'd1, 6'd3);
    load(pl, 0);
    drain(40);
    busy = 1'b0;
    step();
    check("post_abort_idle", 32'({cmd_ready, tx_active, pkt_valid}), 32'b100);

    // Reset in the middle of the payload.
    pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    expect_pkt(2'd2, 6'd5, pl);
    send_cmd(2'd2, 6'd5);
    load(pl, 0);
    step();
    step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    exp_q.delete();
    check("midrst_out", 32'({pkt_valid, data_out}), 0);
    check("midrst_ready", 32'({cmd_ready, tx_active}), 32'b10);
    check("midrst_pulses", 32'({done, abort, cmd_err}), 0);
    step();
    step();

    // Single-byte packet after reset.
    pl = '{8'hA5};
    expect_pkt(2'd0, 6'd1, pl);
    check("a5_parity_model", 32'(exp_q[2].data), 32'hA1);
    send_cmd(2'd0, 6'd1);
    load(pl, 0);
    drain(30);

    // Paced payload: one byte every third cycle.
    pl = '{8'h5A, 8'h3C, 8'h96};
    expect_pkt(2'd1, 6'd3, pl);
    send_cmd(2'd1, 6'd3);
    load(pl, 2);
    check("paced_hdr", 32'({tx_active, pkt_valid, data_out}), 32'({2'b11, 8'h0D}));
    drain(30);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
Packet transmitter that drives the router's input port (pkt_valid / data_in / busy) from a simple host command-and-payload interface.
- Buffers the whole payload (up to 63 bytes) internally, then emits: header {len[5:0], addr[1:0]}, the payload bytes, and an even-XOR parity byte.
- Obeys the router's busy flow control throughout.
- Used as the stimulus and traffic source in front of router_top.

Parameters:
GAP_CYCLES, 2, idle cycles after the parity byte is consumed before done/IDLE (min 1)
BUSY_TO, 255, busy-stall timeout in cycles while a byte is presented; 0 disables; counter width 8

Ports:
clock  in  1  clock, all state on rising edge
resetn  in  1  reset, synchronous, active-low
cmd_valid  in  1  host command strobe
cmd_addr  in  2  destination port 0..2
cmd_len  in  6  payload length 1..63
cmd_ready  out  1  high in IDLE only
pl_valid  in  1  payload byte valid
pl_data  in  8  payload byte
pl_ready  out  1  high in LOAD only
busy  in  1  router busy; a presented byte is consumed on any rising edge where busy==0
pkt_valid  out  1  to router pkt_valid, registered
data_out  out  8  to router data_in, registered
done  out  1  one-cycle pulse, packet complete
abort  out  1  one-cycle pulse, busy timeout
cmd_err  out  1  one-cycle pulse, illegal command rejected
tx_active  out  1  high in HEADER/PAYLOAD/PARITY

Behaviour:
- Reset values: state=IDLE; pkt_valid=0; data_out=0x00; done=abort=cmd_err=0; pointers, parity and counters cleared. Reset in any state aborts immediately with no done/abort pulse; buffer contents are don't-care.
- Storage: 64x8 buffer, write pointer wr_ptr[5:0], read pointer rd_ptr[5:0], combinational read; latched addr/len; parity register par[7:0].
- IDLE:
  - On cmd_valid && cmd_ready, if cmd_addr==3 or cmd_len==0: cmd_err=1 next cycle, stay IDLE.
  - Otherwise latch addr/len, par<=header, wr_ptr<=0, go LOAD.
- LOAD:
  - Each pl_valid && pl_ready: mem[wr_ptr]<=pl_data, par<=par^pl_data, wr_ptr++.
  - On the edge accepting byte number len: go HEADER and, on that same edge, pkt_valid<=1, data_out<=header.
  - pl_valid outside LOAD is ignored.
- HEADER:
  - Hold pkt_valid=1 and data_out=header while busy==1.
  - On an edge with busy==0: data_out<=mem[0], rd_ptr<=1, go PAYLOAD.
- PAYLOAD, on an edge with busy==0:
  - If rd_ptr==len: pkt_valid<=0, data_out<=par, go PARITY.
  - Else data_out<=mem[rd_ptr], rd_ptr++.
  - While busy==1, outputs hold.
- PARITY:
  - pkt_valid=0, data_out=par held.
  - On an edge with busy==0: data_out<=0, go GAP, load gap counter.
- GAP: count GAP_CYCLES cycles, then done=1 for one cycle and go IDLE. busy is ignored in GAP.
- Timeout (BUSY_TO!=0):
  - The stall counter increments each cycle busy==1 in HEADER, PAYLOAD or PARITY, and clears on any consumed byte.
  - When it reaches BUSY_TO: pkt_valid<=0, data_out<=0, abort=1 one cycle, go IDLE.
- Command handshake: cmd_ready==0 outside IDLE, so a cmd_valid arriving then is not accepted and is not queued.
- Parity = XOR of the header and all payload bytes.
- Arithmetic: pointers compare against the 6-bit len, and rd_ptr never wraps (max 63).
- Throughput: one byte per cycle when busy==0.
- Packet duration: HEADER..PARITY takes len+2 consumed bytes, plus GAP_CYCLES.

Test Plan:
- Basic, busy=0 throughout:
  - Stimulus: cmd addr=1 len=3, payload 0x11,0x22,0x33.
  - Response: data_out = 0x0D, 0x11, 0x22, 0x33 with pkt_valid=1, one cycle each; then 0x0D with pkt_valid=0; done pulses GAP_CYCLES+1 cycles after the parity cycle.
- Stall: same packet with busy=1 for 3 cycles while 0x22 is presented → 0x22 held for 4 cycles with pkt_valid=1; the rest of the sequence is unchanged.
- Illegal commands: cmd addr=3 len=5, then addr=0 len=0 → one cmd_err pulse each; pl_ready, pkt_valid and tx_active stay 0; cmd_ready stays 1.
- Maximum length: addr=2 len=63, payload 0x00..0x3E → header 0xFE, 63 bytes in order, parity 0xC1; rd_ptr must not wrap.
- Timeout: BUSY_TO=8, busy=1 held during HEADER → abort on the 8th stall cycle; pkt_valid=0, data_out=0, cmd_ready=1 next cycle, no done.
- Reset and pacing:
  - resetn=0 for 1 cycle mid-PAYLOAD → next cycle pkt_valid=0, data_out=0x00, cmd_ready=1, no pulses.
  - Then a new addr=0 len=1 payload 0xA5 packet → 0x04, 0xA5, then parity 0xA1.
  - pl_valid asserted only every 3rd cycle in LOAD → HEADER entered on the edge accepting the last byte.
